// File: rtl/q15_multiplier_pkg.sv
// Shared arithmetic definitions for the multiplier and its sibling divider.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package q15_multiplier_pkg;

   // Fractional bits of the Q format used by the arithmetic unit.
   localparam int Q15_FRAC_BITS = 15;

   // The divider uses the same op bit: 0 = div, 1 = mod.
   localparam logic OP_MUL_Q15 = 1'b0;
   localparam logic OP_MUL_INT = 1'b1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      FINISH = 2'd2
   } mul_state_t;

endpackage

// File: rtl/q15_multiplier_if.sv
// Launch/busy bus between the execute stage and the multiplier.
// Latency: n/a (wiring only).
// Backpressure: launch is only taken while busy=0; there is no queue.
//   master (execute stage): drives launch, op, a, b; reads busy, overflow, res
//   slave  (multiplier)   : reads launch, op, a, b; drives busy, overflow, res
interface q15_multiplier_if #(
   parameter int WIDTH = 64
);
   logic             launch;
   logic             op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             overflow;
   logic [WIDTH-1:0] res;

   modport master (
      output launch, op, a, b,
      input  busy, overflow, res
   );

   modport slave (
      input  launch, op, a, b,
      output busy, overflow, res
   );
endinterface

// File: rtl/q15_multiplier_shift_add.sv
// Unsigned radix-2 shift-add multiplier core: one partial product per step.
// Latency: WIDTH steps after start; done pulses on the last step.
// Backpressure: none; the caller sequences start/step and ignores inputs otherwise.
//   start     : load magnitudes, clear accumulator and counter
//   step      : perform one iteration
//   mcand_in  : multiplicand magnitude, mplier_in: multiplier magnitude
//   acc       : 2*WIDTH-bit product, complete after the done step
//   done      : high on the step that performs the final iteration
module unsigned_shift_add_multiplier #(
   parameter int WIDTH = 64
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               step,
   input  logic [WIDTH-1:0]   mcand_in,
   input  logic [WIDTH-1:0]   mplier_in,
   output logic [2*WIDTH-1:0] acc,
   output logic               done
);
   localparam int CW = $clog2(WIDTH + 1);

   // The multiplicand is kept pre-shifted, which is equivalent to adding
   // mcand << counter without a barrel shifter in the datapath.
   logic [2*WIDTH-1:0] mcand_sh;
   logic [WIDTH-1:0]   mplier;
   logic [CW-1:0]      counter;

   assign done = step && (counter == CW'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (!reset) begin
         mcand_sh <= '0;
         mplier   <= '0;
         counter  <= '0;
         acc      <= '0;
      end else if (start) begin
         mcand_sh <= {{WIDTH{1'b0}}, mcand_in};
         mplier   <= mplier_in;
         counter  <= '0;
         acc      <= '0;
      end else if (step) begin
         if (mplier[0]) begin
            acc <= acc + mcand_sh;
         end
         mcand_sh <= mcand_sh << 1;
         mplier   <= mplier >> 1;
         counter  <= counter + CW'(1);
      end
   end
endmodule

// File: rtl/q15_multiplier.sv
// Signed multi-cycle multiplier producing a Q15 or integer product with overflow flag.
// Latency: busy high for WIDTH+1 cycles after an accepted launch; result valid when busy falls.
// Backpressure: launch is ignored (not queued) while busy=1, including the edge busy falls.
//   clk, reset : rising-edge clock, synchronous active-low reset
//   bus.launch/op/a/b : request (op 0 = Q15, 1 = integer low WIDTH bits)
//   bus.busy/overflow/res : status and registered result, held until next launch
module q15_multiplier
   import q15_multiplier_pkg::*;
#(
   parameter int WIDTH     = 64,
   parameter int FRAC_BITS = Q15_FRAC_BITS
) (
   input  logic            clk,
   input  logic            reset,
   q15_multiplier_if.slave bus
);
   localparam int PW = 2 * WIDTH;

   mul_state_t state, state_nxt;

   logic             op_q;
   logic             neg_q;
   logic [WIDTH-1:0] res_q;
   logic             ovf_q;

   logic             accept;
   logic             core_step;
   logic             core_done;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic [PW-1:0]    acc;
   logic [PW-1:0]    prod;

   logic [WIDTH-FRAC_BITS:0] q_hi;
   logic [WIDTH:0]           i_hi;
   logic [WIDTH-1:0]         res_nxt;
   logic                     ovf_nxt;

   assign accept = (state == IDLE) && bus.launch;

   // Magnitudes as unsigned: negating the most negative value gives 2^(WIDTH-1),
   // which is exactly representable unsigned.
   assign a_mag = bus.a[WIDTH-1] ? -bus.a : bus.a;
   assign b_mag = bus.b[WIDTH-1] ? -bus.b : bus.b;

   unsigned_shift_add_multiplier #(
      .WIDTH (WIDTH)
   ) u_core (
      .clk       (clk),
      .reset     (reset),
      .start     (accept),
      .step      (core_step),
      .mcand_in  (a_mag),
      .mplier_in (b_mag),
      .acc       (acc),
      .done      (core_done)
   );

   // |product| <= 2^(2*WIDTH-2), so the 2*WIDTH-bit negation cannot wrap.
   assign prod = neg_q ? -acc : acc;

   // Bits above the kept field plus its sign bit; all equal means it fits.
   assign q_hi = prod[PW-1 : FRAC_BITS+WIDTH-1];
   assign i_hi = prod[PW-1 : WIDTH-1];

   always_comb begin
      res_nxt = '0;
      ovf_nxt = 1'b0;
      if (op_q == OP_MUL_INT) begin
         res_nxt = prod[WIDTH-1:0];
         ovf_nxt = !((&i_hi) || !(|i_hi));
      end else begin
         // Plain slice of the two's-complement product = floor toward -inf.
         res_nxt = prod[FRAC_BITS+WIDTH-1 : FRAC_BITS];
         ovf_nxt = !((&q_hi) || !(|q_hi));
      end
   end

   always_comb begin
      state_nxt = state;
      core_step = 1'b0;
      case (state)
         IDLE: begin
            if (bus.launch) state_nxt = RUN;
         end
         RUN: begin
            core_step = 1'b1;
            if (core_done) state_nxt = FINISH;
         end
         FINISH: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
         op_q  <= 1'b0;
         neg_q <= 1'b0;
         res_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            op_q  <= bus.op;
            neg_q <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
         end
         if (state == FINISH) begin
            res_q <= res_nxt;
            ovf_q <= ovf_nxt;
         end
      end
   end

   assign bus.busy     = (state != IDLE);
   assign bus.res      = res_q;
   assign bus.overflow = ovf_q;
endmodule
